// File: rtl/lsu_wb_if.sv
// lsu_wb_if: groups the execute-side handshake, the data-memory read port and
// the register-file write port of the write-back unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN adds the misalign output.
interface lsu_wb_if #(
    parameter int XLEN = 64
);
    // Execute -> write-back
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic            in_is_load;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_data;

    // Data-memory read port
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    // Register-file write port and status
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_ena;
    logic            busy;
    logic [4:0]      busy_rd;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            misalign;
`endif

    // Write-back unit side
    modport slave (
`ifdef LSU_MISALIGN_TRAP_EN
        output misalign,
`endif
        input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output in_ready, mem_req_valid, mem_req_addr,
        output w_addr, w_data, w_ena, busy, busy_rd
    );

    // Environment side (execute stage, memory, register file)
    modport master (
`ifdef LSU_MISALIGN_TRAP_EN
        input  misalign,
`endif
        output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  in_ready, mem_req_valid, mem_req_addr,
        input  w_addr, w_data, w_ena, busy, busy_rd
    );
endinterface

// File: rtl/lsu_wb.sv
// lsu_wb: RV64I write-back unit. ALU results are written one cycle after
// accept; loads issue one aligned doubleword read, then the returned data is
// lane-selected, sign/zero-extended and written to the register file.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned loads raise a
// one-cycle misalign pulse instead of being aligned down.
module lsu_wb #(
    parameter int XLEN = 64
) (
    input  logic     clk,
    input  logic     rst,
    lsu_wb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q;
    logic [4:0]      lat_rd_q;
    logic [2:0]      lat_f3_q;
    logic [2:0]      lat_off_q;
    logic            lat_wen_q;
    logic            req_valid_q;
    logic [XLEN-1:0] req_addr_q;
    logic            w_ena_q;
    logic [4:0]      w_addr_q;
    logic [XLEN-1:0] w_data_q;

    logic            accept_d;
    logic            alu_wb_d;
    logic            start_req_d;
    logic [XLEN-1:0] rsp_lane_d;

    // Select the addressed lane of the returned doubleword and extend it.
    // Offset bits below the access size are ignored, so the lane is aligned down.
    function automatic logic [XLEN-1:0] extract_lane(input logic [XLEN-1:0] data,
                                                     input logic [2:0]      f3,
                                                     input logic [2:0]      off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic [XLEN-1:0] r;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[2:1], 4'b0000} +: 16];
        w = data[{off[2], 5'b00000} +: 32];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            3'b010:  r = {{(XLEN-32){w[31]}}, w};
            3'b110:  r = {{(XLEN-32){1'b0}}, w};
            default: r = data;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    logic trap_d;

    // Offset not a multiple of the access size (funct3[1:0] encodes log2 size).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
        logic m;
        case (f3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = |off[1:0];
            2'b11:   m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign trap_d      = accept_d && bus.in_is_load && is_misaligned(bus.in_funct3, bus.in_data[2:0]);
    assign start_req_d = accept_d && bus.in_is_load && !trap_d;
    assign bus.misalign = misalign_q;
`else
    assign start_req_d = accept_d && bus.in_is_load;
`endif

    assign accept_d   = bus.in_valid && bus.in_ready;
    assign alu_wb_d   = accept_d && !bus.in_is_load;
    assign rsp_lane_d = extract_lane(bus.mem_rsp_data, lat_f3_q, lat_off_q);

    // in_ready is forced low while reset is held and only high in IDLE.
    assign bus.in_ready      = rst && (state_q == IDLE);
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.w_ena         = w_ena_q;
    assign bus.w_addr        = w_addr_q;
    assign bus.w_data        = w_data_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.busy_rd       = (state_q != IDLE) ? lat_rd_q : 5'd0;

    // Control FSM with registered request and write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lat_rd_q    <= 5'd0;
            lat_f3_q    <= 3'd0;
            lat_off_q   <= 3'd0;
            lat_wen_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            w_ena_q     <= 1'b0;
            w_addr_q    <= 5'd0;
            w_data_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            w_ena_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        lat_rd_q  <= bus.in_rd;
                        lat_f3_q  <= bus.in_funct3;
                        lat_off_q <= bus.in_data[2:0];
                        lat_wen_q <= bus.in_wen;
                    end
                    if (alu_wb_d) begin
                        w_ena_q  <= bus.in_wen && (bus.in_rd != 5'd0);
                        w_addr_q <= bus.in_rd;
                        w_data_q <= bus.in_data;
                    end
                    if (start_req_d) begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {bus.in_data[XLEN-1:3], 3'b000};
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    if (trap_d) begin
                        misalign_q <= 1'b1;
                    end
`endif
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        state_q  <= IDLE;
                        w_ena_q  <= lat_wen_q && (lat_rd_q != 5'd0);
                        w_addr_q <= lat_rd_q;
                        w_data_q <= rsp_lane_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: self-checking bench for lsu_wb with directed and random
// ALU/load traffic checked against a behavioural load-result model.
// Honours LSU_MISALIGN_TRAP_EN when the design is built with it.
module tb_lsu_wb;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    lsu_wb_if #(.XLEN(64)) bus ();

    lsu_wb #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: shift the addressed bytes down, mask to size, extend.
    function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] f3,
                                             input logic [2:0] off);
        int          sz;
        int          aoff;
        logic [63:0] v;
        logic [63:0] mask;
        sz   = 1 << f3[1:0];
        aoff = (int'(off) / sz) * sz;
        v    = d >> (8 * aoff);
        if (sz == 8) return v;
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [2:0] off);
        int sz;
        sz = 1 << f3[1:0];
        return (int'(off) % sz) != 0;
    endfunction

    logic [4:0]  q_rd  [8];
    logic        q_wen [8];
    logic [63:0] q_dat [8];

    // Issue n back-to-back ALU results from the q_* tables.
    task automatic alu_burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_is_load = 1'b0;
            bus.in_rd      = q_rd[i];
            bus.in_wen     = q_wen[i];
            bus.in_funct3  = 3'($urandom_range(7));
            bus.in_data    = q_dat[i];
            check("alu_in_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
            check("alu_w_ena", 64'(bus.w_ena), 64'(q_wen[i] && (q_rd[i] != 5'd0)));
            if (q_wen[i] && (q_rd[i] != 5'd0)) begin
                check("alu_w_addr", 64'(bus.w_addr), 64'(q_rd[i]));
                check("alu_w_data", bus.w_data, q_dat[i]);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("alu_w_ena_end", 64'(bus.w_ena), 64'd0);
    endtask

    // One complete load: accept, request with stall, response after delay.
    task automatic load_op(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                           input logic [63:0] addr, input int stall, input int dly,
                           input logic [63:0] rsp, input logic [63:0] exp);
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_rd      = rd;
        bus.in_wen     = wen;
        bus.in_funct3  = f3;
        bus.in_data    = addr;
        check("ld_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (ref_misaligned(f3, addr[2:0])) begin
            check("trap_misalign", 64'(bus.misalign), 64'd1);
            check("trap_req_valid", 64'(bus.mem_req_valid), 64'd0);
            check("trap_w_ena", 64'(bus.w_ena), 64'd0);
            check("trap_in_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
            check("trap_misalign_end", 64'(bus.misalign), 64'd0);
            check("trap_w_ena_end", 64'(bus.w_ena), 64'd0);
            return;
        end
`endif
        check("ld_req_valid", 64'(bus.mem_req_valid), 64'd1);
        check("ld_req_addr", bus.mem_req_addr, addr & ~64'd7);
        check("ld_busy", 64'(bus.busy), 64'd1);
        check("ld_busy_rd", 64'(bus.busy_rd), 64'(rd));
        check("ld_in_ready_busy", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_req_valid", 64'(bus.mem_req_valid), 64'd1);
            check("stall_req_addr", bus.mem_req_addr, addr & ~64'd7);
            check("stall_busy_rd", 64'(bus.busy_rd), 64'(rd));
        end
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        check("wait_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("wait_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            check("wait_w_ena", 64'(bus.w_ena), 64'd0);
            check("wait_busy_rd", 64'(bus.busy_rd), 64'(rd));
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = rsp;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = {$urandom, $urandom};
        check("ld_w_ena", 64'(bus.w_ena), 64'(wen && (rd != 5'd0)));
        if (wen && (rd != 5'd0)) begin
            check("ld_w_addr", 64'(bus.w_addr), 64'(rd));
            check("ld_w_data", bus.w_data, exp);
        end
        check("ld_done_ready", 64'(bus.in_ready), 64'd1);
        check("ld_done_busy_rd", 64'(bus.busy_rd), 64'd0);
        @(posedge clk); #1;
        check("ld_w_ena_single", 64'(bus.w_ena), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [2:0]  f;
        logic [4:0]  r;
        logic        w;
        n_checks = 0;
        n_fail   = 0;
        rst               = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_rd         = 5'd0;
        bus.in_wen        = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_funct3     = 3'd0;
        bus.in_data       = 64'd0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 64'd0;

        // Values while reset is held
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_req_addr", bus.mem_req_addr, 64'd0);
        check("rst_w_ena", 64'(bus.w_ena), 64'd0);
        check("rst_w_addr", 64'(bus.w_addr), 64'd0);
        check("rst_w_data", bus.w_data, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_busy_rd", 64'(bus.busy_rd), 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("rst_misalign", 64'(bus.misalign), 64'd0);
`endif
        #10 rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // ALU directed: single write, then three back-to-back, then rd=x0
        q_rd[0] = 5'd5; q_wen[0] = 1'b1; q_dat[0] = 64'h1234;
        alu_burst(1);
        q_rd[0] = 5'd1; q_wen[0] = 1'b1; q_dat[0] = 64'hAAAA_0000_0000_0001;
        q_rd[1] = 5'd2; q_wen[1] = 1'b1; q_dat[1] = 64'h5555_0000_0000_0002;
        q_rd[2] = 5'd31; q_wen[2] = 1'b1; q_dat[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        alu_burst(3);
        q_rd[0] = 5'd0; q_wen[0] = 1'b1; q_dat[0] = 64'hDEAD;
        q_rd[1] = 5'd7; q_wen[1] = 1'b0; q_dat[1] = 64'hBEEF;
        alu_burst(2);

        // Load directed cases
        load_op(5'd9, 1'b1, 3'b000, 64'h1003, 3, 2, 64'h0000_0000_8000_0000,
                64'hFFFF_FFFF_FFFF_FF80);
        load_op(5'd10, 1'b1, 3'b110, 64'h2004, 0, 0, 64'hDEADBEEF_00000000,
                64'h0000_0000_DEAD_BEEF);
        load_op(5'd11, 1'b1, 3'b010, 64'h2004, 1, 1, 64'hDEADBEEF_00000000,
                64'hFFFF_FFFF_DEAD_BEEF);
        load_op(5'd0, 1'b1, 3'b011, 64'h3000, 0, 1, 64'h0123_4567_89AB_CDEF, 64'd0);
        load_op(5'd12, 1'b1, 3'b001, 64'h4001, 0, 0, 64'h1122_3344_5566_8001,
                64'hFFFF_FFFF_FFFF_8001);
        load_op(5'd13, 1'b1, 3'b111, 64'h4006, 0, 0, 64'h8877_6655_4433_2211,
                64'h8877_6655_4433_2211);

        // Reset asserted while waiting for the response
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_rd      = 5'd20;
        bus.in_wen     = 1'b1;
        bus.in_funct3  = 3'b011;
        bus.in_data    = 64'h5000;
        @(posedge clk); #1;
        bus.in_valid      = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        check("rw_busy_wait", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        check("rw_in_ready_rst", 64'(bus.in_ready), 64'd0);
        check("rw_busy_rst", 64'(bus.busy), 64'd0);
        check("rw_busy_rd_rst", 64'(bus.busy_rd), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        check("rw_stale_w_ena", 64'(bus.w_ena), 64'd0);
        check("rw_in_ready", 64'(bus.in_ready), 64'd1);
        check("rw_busy", 64'(bus.busy), 64'd0);

        // Random mix of ALU bursts and loads
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(2) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    q_rd[k]  = 5'($urandom_range(31));
                    q_wen[k] = ($urandom_range(3) != 0);
                    q_dat[k] = {$urandom, $urandom};
                end
                alu_burst(int'($urandom_range(1, 4)));
            end else begin
                f = 3'($urandom_range(7));
                a = {$urandom, $urandom};
                d = {$urandom, $urandom};
                r = 5'($urandom_range(31));
                w = ($urandom_range(3) != 0);
                load_op(r, w, f, a, int'($urandom_range(3)), int'($urandom_range(3)), d,
                        ref_load(d, f, a[2:0]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Write-back unit that produces the register-file write port (`w_addr`/`w_data`/`w_ena`) for the RV64I core. It accepts one retired result per handshake from execute. ALU results are written straight through. Loads trigger a single memory read transaction; the returned doubleword is lane-selected, sign- or zero-extended, and then written. It sits between execute, the data-memory port, and the register file's write port.

## Interface
- `XLEN`, 64: data/address width; matches `REG_BUS`.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  execute presents a result.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `in_rd`  in  5  destination register.
- `in_wen`  in  1  instruction writes rd.
- `in_is_load`  in  1  `in_data` is a load address.
- `in_funct3`  in  3  load type (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110).
- `in_data`  in  XLEN  ALU result or load address.
- `mem_req_valid`  out  1  read request.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  XLEN  address, aligned down to 8 bytes.
- `mem_rsp_valid`  in  1  read data valid (one-cycle pulse).
- `mem_rsp_data`  in  XLEN  aligned doubleword.
- `w_addr`  out  5  to register file.
- `w_data`  out  XLEN  to register file.
- `w_ena`  out  1  to register file; single-cycle pulse.
- `busy`  out  1  load in flight (state != IDLE).
- `busy_rd`  out  5  rd of the in-flight load; 0 when idle.

## Operation
- States: IDLE, REQ, WAIT.
- Accept happens when `in_valid && in_ready`. Fields are latched into `lat_rd`, `lat_f3`, `lat_off = in_data[2:0]`, and `lat_wen`.
- Non-load accept: the unit stays in IDLE. On the next cycle it drives `w_ena = in_wen && (in_rd != 0)`, `w_addr = in_rd`, `w_data = in_data`.
- Load accept: IDLE -> REQ. While in REQ, `mem_req_valid = 1` and `mem_req_addr = {addr[XLEN-1:3], 3'b000}`. Both are held stable until `mem_req_ready`, then the unit moves REQ -> WAIT.
- In WAIT, on `mem_rsp_valid` the unit moves WAIT -> IDLE. On the next cycle it writes the extracted value, with `w_ena = lat_wen && (lat_rd != 0)`.
- Lane extraction:
  - byte = data[8*off +: 8]
  - half = data[16*off[2:1] +: 16]
  - word = data[32*off[2] +: 32]
  - LD / funct3 111 uses the whole doubleword.
  - Signed types sign-extend from the top bit of the lane. Unsigned types zero-extend.
- Misalignment: low offset bits below the access size are ignored (lane aligned down), unless the configuration macro below is defined.
- `mem_rsp_valid` outside WAIT is ignored.
- `busy_rd = lat_rd` in REQ/WAIT, else 0.
- rd = x0: no write pulse is generated, but the load still performs its memory transaction.

## Timing
- Reset (async assert, sync release): state IDLE. `in_ready` = 1 after reset and 0 during it. `mem_req_valid`, `mem_req_addr`, `w_ena`, `w_addr`, `w_data`, `busy`, `busy_rd` are all 0.
- ALU latency: accept at cycle N, `w_ena` at N+1. Throughput is one per cycle back-to-back.
- Load latency:
  - Accept at N; `mem_req_valid` from N+1.
  - If ready at N+1, WAIT from N+2.
  - Response at cycle M ≥ N+2; `w_ena` at M+1.
  - `in_ready` returns high at M+1, so a new accept can occur at M+1.
- `w_ena` is never high for two cycles from one accept. Write outputs are registered.
- Reset asserted mid-load: the transaction is abandoned and the state returns to IDLE. A later stale response is ignored, because it arrives in IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Adds output `misalign` (1 bit, reset 0).
  - A load with an offset not aligned to its size (half: off[0]; word: off[1:0]; dword: off[2:0]) does not enter REQ and issues no memory request.
  - The unit stays in IDLE, pulses `misalign` for one cycle at N+1, and produces no `w_ena`.
- Not defined: no `misalign` port; misaligned offsets are aligned down as in Operation.

## Test plan
- Reset, then ALU rd=5, data 0x1234 -> at N+1: `w_ena`=1, `w_addr`=5, `w_data`=0x1234. Three back-to-back ALU ops -> three consecutive `w_ena` pulses.
- ALU rd=0, `in_wen`=1 -> `w_ena` stays 0.
- LB at address 0x1003, `mem_req_ready` held low 3 cycles, response 0x0000_0000_8000_0000 -> `mem_req_addr`=0x1000 held stable through the stall; `w_data`=0xFFFF_FFFF_FFFF_FF80; `busy`/`busy_rd` valid throughout.
- LWU offset 4, response 0xDEADBEEF_00000000 -> `w_data`=0x0000_0000_DEAD_BEEF. LW with the same response -> 0xFFFF_FFFF_DEAD_BEEF.
- Reset asserted in WAIT, released, then `mem_rsp_valid` pulse -> no `w_ena`; `in_ready`=1.
- With `LSU_MISALIGN_TRAP_EN`: LH offset 1 -> `misalign` pulse, no `mem_req_valid`, no `w_ena`. Without the macro -> lane at offset 0 is written.
